term_tx_arbiter: RTL and testbench

- Shares one UART transmitter between two byte-stream sources: A = local echo / command path, B = termbuffer screen output (o_serial/o_serial_v).
- Round-robin per byte, except ANSI escape sequences: a source that starts an ESC sequence keeps the grant until the sequence ends, so the terminal never sees interleaved sequences.
- A lock timeout stops a stalled source from hogging the transmitter.
- Sits between termbuffer and the UART TX.

---
 rtl/term_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_term_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_tx_arbiter.sv
// rtl/term_tx_arbiter.sv - two-source UART TX arbiter with per-byte round-robin and ANSI escape locking
// Optional CR insertion before LF when TERM_TX_ARBITER_CRLF_EN is defined.
module term_tx_arbiter #(
   parameter int LOCK_TIMEOUT = 255,
   parameter int TW           = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_a_data,
   input  logic       i_a_v,
   output logic       o_a_ack,
   input  logic [7:0] i_b_data,
   input  logic       i_b_v,
   output logic       o_b_ack,
   output logic [7:0] o_tx_data,
   output logic       o_tx_v,
   input  logic       i_tx_ready,
   output logic       o_grant,
   output logic       o_locked,
   output logic       o_lock_timeout
);

   typedef enum logic {S_IDLE, S_HOLD} state_t;
   typedef enum logic [1:0] {P_NONE, P_ESC, P_CSI} parse_t;

   state_t        state;
   parse_t        parser;
   parse_t        parser_nx;
   logic [TW-1:0] cnt;
   logic          hold_grant;
   logic          gnt_v;
   logic          sel_v;
   logic          sel;
   logic          expand;
   logic [7:0]    sel_data;
   logic [7:0]    tx_byte;

`ifdef TERM_TX_ARBITER_CRLF_EN
   logic       lf_pend;
   logic [1:0] cr_seen;

   // The inserted CR keeps the grant so the LF that follows cannot be overtaken.
   assign hold_grant = o_locked || lf_pend;
   assign expand     = (sel_data == 8'h0A) && !lf_pend && !cr_seen[sel];
`else
   assign hold_grant = o_locked;
   assign expand     = 1'b0;
`endif

   assign o_locked = (parser != P_NONE);
   assign gnt_v    = o_grant ? i_b_v : i_a_v;
   assign sel_data = sel ? i_b_data : i_a_data;
   assign tx_byte  = expand ? 8'h0D : sel_data;

   always_comb begin
      sel_v = 1'b0;
      sel   = o_grant;
      if (state == S_IDLE && i_tx_ready) begin
         if (hold_grant) begin
            sel_v = gnt_v;
         end else if (i_a_v && i_b_v) begin
            sel_v = 1'b1;
            sel   = ~o_grant;
         end else if (i_a_v || i_b_v) begin
            sel_v = 1'b1;
            sel   = i_b_v;
         end
      end
   end

   always_comb begin
      parser_nx = parser;
      if (tx_byte == 8'h1B) begin
         parser_nx = P_ESC;
      end else begin
         case (parser)
            P_ESC:   parser_nx = (tx_byte == 8'h5B) ? P_CSI : P_NONE;
            P_CSI:   if (tx_byte >= 8'h40 && tx_byte <= 8'h7E) parser_nx = P_NONE;
            default: parser_nx = P_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         parser         <= P_NONE;
         cnt            <= '0;
         o_tx_v         <= 1'b0;
         o_tx_data      <= 8'h00;
         o_a_ack        <= 1'b0;
         o_b_ack        <= 1'b0;
         o_grant        <= 1'b1;
         o_lock_timeout <= 1'b0;
`ifdef TERM_TX_ARBITER_CRLF_EN
         lf_pend        <= 1'b0;
         cr_seen        <= 2'b00;
`endif
      end else begin
         o_tx_v         <= 1'b0;
         o_a_ack        <= 1'b0;
         o_b_ack        <= 1'b0;
         o_lock_timeout <= 1'b0;
         if (state == S_HOLD) begin
            state <= S_IDLE;
         end else if (sel_v) begin
            state     <= S_HOLD;
            o_tx_v    <= 1'b1;
            o_tx_data <= tx_byte;
            o_grant   <= sel;
            o_a_ack   <= !sel && !expand;
            o_b_ack   <= sel && !expand;
            parser    <= parser_nx;
            cnt       <= '0;
`ifdef TERM_TX_ARBITER_CRLF_EN
            lf_pend      <= expand;
            cr_seen[sel] <= (tx_byte == 8'h0D);
`endif
         end else if (o_locked && i_tx_ready && !gnt_v) begin
            // A locked source that stops offering bytes releases the TX after LOCK_TIMEOUT idle cycles.
            if (cnt == TW'(LOCK_TIMEOUT - 1)) begin
               parser         <= P_NONE;
               cnt            <= '0;
               o_lock_timeout <= 1'b1;
            end else begin
               cnt <= cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_term_tx_arbiter.sv
// tb/tb_term_tx_arbiter.sv - randomized self-checking bench for term_tx_arbiter
module tb_term_tx_arbiter;
   localparam int LT = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] i_a_data, i_b_data, o_tx_data;
   logic       i_a_v, i_b_v, o_a_ack, o_b_ack, o_tx_v, i_tx_ready;
   logic       o_grant, o_locked, o_lock_timeout;

   int checks = 0;
   int errors = 0;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       rdy;

   logic       m_busy, m_grant, lf_pend, pa, pb;
   logic [1:0] last_cr;
   logic [7:0] seq[$];
   int         m_idle;
   logic [13:0] expv;

   always #5 clk = ~clk;

   term_tx_arbiter #(.LOCK_TIMEOUT(LT), .TW(16)) dut (
      .clk(clk), .rst(rst),
      .i_a_data(i_a_data), .i_a_v(i_a_v), .o_a_ack(o_a_ack),
      .i_b_data(i_b_data), .i_b_v(i_b_v), .o_b_ack(o_b_ack),
      .o_tx_data(o_tx_data), .o_tx_v(o_tx_v), .i_tx_ready(i_tx_ready),
      .o_grant(o_grant), .o_locked(o_locked), .o_lock_timeout(o_lock_timeout)
   );

   function automatic logic [13:0] obs();
      return {o_tx_v, (o_tx_v ? o_tx_data : 8'h00), o_a_ack, o_b_ack, o_grant, o_locked, o_lock_timeout};
   endfunction

   // An escape sequence is open until ESC+non-'[' or ESC '[' ... final byte 0x40..0x7E.
   function automatic logic seq_open();
      logic [7:0] last;
      if (seq.size() < 2) return 1'b1;
      if (seq[1] != 8'h5B) return 1'b0;
      if (seq.size() == 2) return 1'b1;
      last = seq[seq.size()-1];
      return !(last >= 8'h40 && last <= 8'h7E);
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_grant = 1'b1; lf_pend = 1'b0; last_cr = 2'b00;
      seq.delete(); m_idle = 0; pa = 1'b0; pb = 1'b0;
   endtask

   task automatic model_step();
      logic av, bv, c, go, ack, to;
      logic [7:0] s, d;
      av = qa.size() > 0; bv = qb.size() > 0;
      go = 1'b0; c = m_grant; d = 8'h00; ack = 1'b0; to = 1'b0;
      if (m_busy) begin
         m_busy = 1'b0;
      end else if (rdy) begin
         if (seq.size() > 0 || lf_pend) begin
            go = m_grant ? bv : av;
         end else if (av && bv) begin
            c = !m_grant; go = 1'b1;
         end else if (av || bv) begin
            c = bv; go = 1'b1;
         end
         if (go) begin
            s = c ? qb[0] : qa[0];
            d = s; ack = 1'b1;
`ifdef TERM_TX_ARBITER_CRLF_EN
            if (s == 8'h0A && !lf_pend && !last_cr[c]) begin
               d = 8'h0D; ack = 1'b0; lf_pend = 1'b1;
            end else begin
               lf_pend = 1'b0;
            end
            last_cr[c] = (d == 8'h0D);
`endif
            m_grant = c; m_busy = 1'b1; m_idle = 0;
            if (d == 8'h1B) begin
               seq.delete(); seq.push_back(d);
            end else if (seq.size() > 0) begin
               seq.push_back(d);
               if (!seq_open()) seq.delete();
            end
         end else if (seq.size() > 0) begin
            m_idle++;
            if (m_idle == LT) begin
               seq.delete(); m_idle = 0; to = 1'b1;
            end
         end
      end
      pa = go && ack && !c;
      pb = go && ack && c;
      expv = {go, d, pa, pb, m_grant, (seq.size() > 0), to};
   endtask

   task automatic drive();
      i_a_v = qa.size() > 0; i_a_data = i_a_v ? qa[0] : 8'h00;
      i_b_v = qb.size() > 0; i_b_data = i_b_v ? qb[0] : 8'h00;
      i_tx_ready = rdy;
   endtask

   task automatic tick();
      drive();
      model_step();
      @(posedge clk); #1;
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b0; qa.delete(); qb.delete(); rdy = 1'b1; drive();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0; #2;
      checks++;
      if ({o_tx_v, o_tx_data, o_a_ack, o_b_ack, o_grant, o_locked, o_lock_timeout} !== 14'b0_00000000_0_0_1_0_0) begin
         errors++;
         $display("FAIL reset_values got %h exp %h", {o_tx_v, o_tx_data, o_a_ack, o_b_ack, o_grant, o_locked, o_lock_timeout}, 14'b0_00000000_0_0_1_0_0);
      end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [7:0] first;
      int n;
      do_reset();
      first = 8'h00; n = 0;
      repeat (6) begin qa.push_back(8'h61); qb.push_back(8'h62); end
      repeat (30) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL round_robin t=%0t got %h exp %h", $time, obs(), expv); end
         if (o_tx_v) begin if (n == 0) first = o_tx_data; n++; end
      end
      checks++;
      if (first !== 8'h61) begin errors++; $display("FAIL rr_first got %h exp 61", first); end
      checks++;
      if (n != 12) begin errors++; $display("FAIL rr_count got %0d exp 12", n); end
   endtask

   task automatic test_single();
      qa.push_back(8'h6C);
      repeat (6) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL single t=%0t got %h exp %h", $time, obs(), expv); end
      end
   endtask

   task automatic test_escape();
      logic [7:0] got[$];
      logic [7:0] want[5];
      want = '{8'h1B, 8'h5B, 8'h32, 8'h4A, 8'h78};
      qb = '{8'h1B, 8'h5B, 8'h32, 8'h4A};
      for (int i = 0; i < 16; i++) begin
         if (i == 1) qa.push_back(8'h78);
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL escape t=%0t got %h exp %h", $time, obs(), expv); end
         if (o_tx_v) got.push_back(o_tx_data);
      end
      checks++;
      if (got.size() != 5) begin
         errors++; $display("FAIL escape_len got %0d exp 5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== want[i]) begin errors++; $display("FAIL escape_order[%0d] got %h exp %h", i, got[i], want[i]); end
         end
      end
   endtask

   task automatic test_timeout();
      int pulses;
      logic [7:0] last;
      pulses = 0; last = 8'h00;
      qb = '{8'h1B, 8'h5B};
      for (int i = 0; i < 30; i++) begin
         if (i == 1) qa.push_back(8'h41);
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL timeout t=%0t got %h exp %h", $time, obs(), expv); end
         if (o_lock_timeout) pulses++;
         if (o_tx_v) last = o_tx_data;
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
      checks++;
      if (last !== 8'h41 || o_locked !== 1'b0) begin errors++; $display("FAIL timeout_after got %h/%b exp 41/0", last, o_locked); end
   endtask

   task automatic test_not_ready();
      int n;
      logic prev;
      n = 0; prev = 1'b0;
      rdy = 1'b0;
      qa = '{8'h31, 8'h32}; qb = '{8'h33, 8'h34};
      repeat (10) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL not_ready t=%0t got %h exp %h", $time, obs(), expv); end
         if (o_tx_v || o_a_ack || o_b_ack) n++;
      end
      checks++;
      if (n != 0) begin errors++; $display("FAIL not_ready_quiet got %0d exp 0", n); end
      rdy = 1'b1;
      repeat (12) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL ready_rise t=%0t got %h exp %h", $time, obs(), expv); end
         checks++;
         if (prev && o_tx_v) begin errors++; $display("FAIL back_to_back got consecutive strobes exp gap"); end
         if (o_tx_v) n++;
         prev = o_tx_v;
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL ready_count got %0d exp 4", n); end
   endtask

   task automatic test_crlf();
      qa.push_back(8'h0A);
      repeat (8) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL crlf_lf t=%0t got %h exp %h", $time, obs(), expv); end
      end
      qa = '{8'h0D, 8'h0A};
      repeat (8) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL crlf_crlf t=%0t got %h exp %h", $time, obs(), expv); end
      end
   endtask

   function automatic logic [7:0] rand_byte();
      logic [7:0] tbl[10];
      tbl = '{8'h1B, 8'h5B, 8'h0A, 8'h0D, 8'h41, 8'h32, 8'h3B, 8'h7E, 8'h40, 8'h61};
      if ($urandom_range(1) == 0) return tbl[$urandom_range(9)];
      return 8'($urandom);
   endfunction

   task automatic test_random();
      repeat (600) begin
         if (qa.size() < 3 && $urandom_range(3) == 0) qa.push_back(rand_byte());
         if (qb.size() < 3 && $urandom_range(3) == 0) qb.push_back(rand_byte());
         rdy = ($urandom_range(7) != 0);
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL random t=%0t got %h exp %h", $time, obs(), expv); end
      end
      rdy = 1'b1;
      repeat (40) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL random_drain t=%0t got %h exp %h", $time, obs(), expv); end
      end
   endtask

   task automatic test_reset_mid();
      qb = '{8'h1B, 8'h5B, 8'h33};
      repeat (2) tick();
      rst = 1'b0; #2;
      checks++;
      if ({o_tx_v, o_tx_data, o_a_ack, o_b_ack, o_grant, o_locked, o_lock_timeout} !== 14'b0_00000000_0_0_1_0_0) begin
         errors++;
         $display("FAIL reset_mid got %h exp %h", {o_tx_v, o_tx_data, o_a_ack, o_b_ack, o_grant, o_locked, o_lock_timeout}, 14'b0_00000000_0_0_1_0_0);
      end
      model_reset();
      @(negedge clk); rst = 1'b1;
      repeat (10) begin
         tick(); checks++;
         if (obs() !== expv) begin errors++; $display("FAIL reset_mid_resume t=%0t got %h exp %h", $time, obs(), expv); end
      end
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; drive();
      test_reset();
      test_round_robin();
      test_single();
      test_escape();
      test_timeout();
      test_not_ready();
      test_crlf();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
